// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC, single-outstanding imem fetch FSM, IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pc_pend_q, pc_pend_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] pend_plus4;
    logic        can_load;
    logic        load_rsp;
    logic        load_hold;

    assign pend_plus4 = pc_pend_q + 32'd4;
    // A flush bubbles IF/ID, so a response arriving then must be parked and delivered later
    assign can_load   = ~StallD & ~FlushD;

    assign imem_req_valid = (state_q == S_REQ) & ~StallF & ~PCSrcE;
    assign imem_req_addr  = pcf_q;

    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        pc_pend_d = pc_pend_q;
        hold_d    = hold_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        load_rsp  = 1'b0;
        load_hold = 1'b0;

        case (state_q)
            S_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    pc_pend_d = pcf_q;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    pcf_d = pend_plus4;
                    if (can_load) begin
                        load_rsp = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        hold_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (can_load) begin
                    load_hold = 1'b1;
                    state_d   = S_REQ;
                end
            end
            default: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
        endcase

        if (load_rsp || load_hold) begin
            instr_d = load_rsp ? imem_rsp_data : hold_q;
            pcd_d   = pc_pend_q;
            pcp4_d  = pend_plus4;
            valid_d = 1'b1;
        end else if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end

        // Redirect overrides every fetch and IF/ID decision made above
        if (PCSrcE) begin
            pcf_d   = PCTargetE & ~32'h3;
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
            if (state_q == S_WAIT) begin
                state_d = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (state_q == S_HOLD) begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pcf_q     <= RESET_PC;
            pc_pend_q <= 32'd0;
            hold_q    <= 32'd0;
            instr_q   <= NOP_INSTR;
            pcd_q     <= 32'd0;
            pcp4_q    <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            pc_pend_q <= pc_pend_d;
            hold_q    <= hold_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcp4_q    <= pcp4_d;
            valid_q   <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a transaction-level model
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    int total = 0;
    int bad   = 0;

    // memory environment
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min = 1;
    int          lat_max = 1;

    // reference model: one outstanding fetch, optional parked response, expected IF/ID
    bit          m_out, m_live, m_held;
    logic [31:0] m_pc, m_pend;
    logic [31:0] e_instr, e_pcd, e_pc4;
    logic        e_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        e_instr = 32'h0000_0013;
        e_pcd   = 32'd0;
        e_pc4   = 32'd0;
        e_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_out  = 1'b0;
        m_live = 1'b0;
        m_held = 1'b0;
        m_pc   = 32'd0;
        m_pend = 32'd0;
        bubble();
    endtask

    task automatic step();
        bit          exp_req, acc, arrive, cand, dut_acc;
        logic [31:0] a;
        @(negedge clk);
        exp_req = !m_out && !m_held && !StallF && !PCSrcE;
        if (!rst) begin
            chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        end
        dut_acc = imem_req_valid && imem_req_ready;
        a       = imem_req_addr;
        if (rst) begin
            model_reset();
        end else begin
            acc    = exp_req && imem_req_ready;
            arrive = imem_rsp_valid && m_out;
            cand   = m_held || (arrive && m_live);
            if (arrive) m_out = 1'b0;
            if (PCSrcE) begin
                m_held = 1'b0;
                m_live = 1'b0;
                m_pc   = PCTargetE & ~32'h3;
                bubble();
            end else if (cand && !StallD && !FlushD) begin
                e_instr = mem_word(m_pend);
                e_pcd   = m_pend;
                e_pc4   = m_pend + 32'd4;
                e_valid = 1'b1;
                m_held  = 1'b0;
            end else begin
                if (cand) m_held = 1'b1;
                if (FlushD) bubble();
            end
            if (acc) begin
                m_out  = 1'b1;
                m_live = 1'b1;
                m_pend = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("InstrD", InstrD, e_instr);
        chk("PCD", PCD, e_pcd);
        chk("PCPlus4D", PCPlus4D, e_pc4);
        chk("ValidD", 32'(ValidD), 32'(e_valid));
        imem_rsp_valid = 1'b0;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (dut_acc) begin
                mem_busy = 1'b1;
                mem_cnt  = int'($urandom_range(lat_max, lat_min));
                mem_addr = a;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                    mem_busy       = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 12 && ValidD !== 1'b1; i++) step();
        chk(tag, 32'(ValidD), 32'd1);
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'd0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
        model_reset();

        // reset
        step(); step();
        rst = 1'b0;
        chk("t1_req_addr", imem_req_addr, 32'h0);
        chk("t1_instr", InstrD, 32'h13);
        chk("t1_valid", 32'(ValidD), 32'd0);
        chk("t1_pcd", PCD, 32'd0);

        // 1-cycle memory stream
        step(); step();
        chk("t2_instr0", InstrD, 32'h0050_0093);
        chk("t2_pcd0", PCD, 32'h0);
        chk("t2_pc40", PCPlus4D, 32'h4);
        step(); step();
        chk("t2_instr1", InstrD, 32'h00A0_0113);
        chk("t2_pcd1", PCD, 32'h4);
        chk("t2_pc41", PCPlus4D, 32'h8);

        // StallD while the response for PC=8 arrives
        step();
        StallD = 1'b1;
        step(); step(); step();
        chk("t3_held_instr", InstrD, 32'h00A0_0113);
        chk("t3_held_pcd", PCD, 32'h4);
        StallD = 1'b0;
        step();
        chk("t3_instr", InstrD, mem_word(32'h8));
        chk("t3_pcd", PCD, 32'h8);
        chk("t3_next_addr", imem_req_addr, 32'hC);

        // redirect while waiting on a slow response
        lat_min = 3; lat_max = 3;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
        step();
        PCSrcE = 1'b0;
        chk("t4_valid", 32'(ValidD), 32'd0);
        chk("t4_instr", InstrD, 32'h13);
        wait_valid("t4_deliver");
        chk("t4_pcd", PCD, 32'h100);

        // redirect with same-cycle response, then redirect while a response is parked
        lat_min = 1; lat_max = 1;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        step();
        PCSrcE = 1'b0;
        chk("t5a_valid", 32'(ValidD), 32'd0);
        step();
        StallD = 1'b1;
        step();
        StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        step();
        PCSrcE = 1'b0;
        chk("t5b_valid", 32'(ValidD), 32'd0);
        chk("t5b_instr", InstrD, 32'h13);
        wait_valid("t5_deliver");
        chk("t5_pcd", PCD, 32'h300);

        // PC wrap, target low bits masked
        step();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        step();
        PCSrcE = 1'b0;
        wait_valid("t6_deliver");
        chk("t6_pcd", PCD, 32'hFFFF_FFFC);
        chk("t6_pc4", PCPlus4D, 32'h0);
        chk("t6_next_addr", imem_req_addr, 32'h0);

        // reset in the middle of a pending fetch
        lat_min = 3; lat_max = 3;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(ValidD), 32'd0);
        chk("t6_rst_addr", imem_req_addr, 32'h0);
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_no_late", 32'(ValidD), 32'd0);
        StallF = 1'b0;

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            rst            = ($urandom % 150) == 0;
            StallF         = ($urandom % 4) == 0;
            StallD         = ($urandom % 4) == 0;
            FlushD         = ($urandom % 8) == 0;
            PCSrcE         = ($urandom % 10) == 0;
            PCTargetE      = $urandom;
            imem_req_ready = ($urandom % 4) != 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
